// File: rtl/uart_receiver_if.sv
// Receive-side signal bundle: the serial line in, the delivered byte and its status flags out.
// master = the receiver itself, slave = the line driver / byte consumer.
interface uart_receiver_if #(
  parameter int DATA_W = 8
) ();
  logic              RX_in;
  logic [DATA_W-1:0] RX_data_out;
  logic              RX_valid;
  logic              RX_busy;
  logic              RX_parity_err;
  logic              RX_frame_err;

  modport master (
    input  RX_in,
    output RX_data_out,
    output RX_valid,
    output RX_busy,
    output RX_parity_err,
    output RX_frame_err
  );

  modport slave (
    output RX_in,
    input  RX_data_out,
    input  RX_valid,
    input  RX_busy,
    input  RX_parity_err,
    input  RX_frame_err
  );
endinterface

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: start, DATA_W bits LSB first, parity, stop; 1-clock valid strobe with error flags.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre (all decisions one clock later).
module uart_receiver #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_W     = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic             clock,
  input  logic             reset,
  uart_receiver_if.master  rx
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);
  localparam logic              PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t              state_q, state_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [BIT_W-1:0]    bitCnt_q, bitCnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_q, par_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                perr_q, perr_d;
  logic                ferr_q, ferr_d;
  logic                valid_q, valid_d;
  logic                sync1_q, rxS_q, rxPrev_q;
  logic                sampleBit;

`ifdef UART_RX_MAJORITY_EN
  // Deciding one tick late lets the vote span the centre sample and both neighbours.
  localparam logic [TICK_W-1:0] START_TICK = TICK_W'(OVERSAMPLE / 2);
  logic rxPrev2_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rxPrev2_q <= 1'b1;
    end else begin
      rxPrev2_q <= rxPrev_q;
    end
  end

  assign sampleBit = (rxS_q & rxPrev_q) | (rxS_q & rxPrev2_q) | (rxPrev_q & rxPrev2_q);
`else
  localparam logic [TICK_W-1:0] START_TICK = TICK_W'(OVERSAMPLE / 2 - 1);

  assign sampleBit = rxS_q;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b1;
      rxS_q    <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      sync1_q  <= rx.RX_in;
      rxS_q    <= sync1_q;
      rxPrev_q <= rxS_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      bitCnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      data_q   <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bitCnt_q <= bitCnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      data_q   <= data_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tick_d   = (tick_q == LAST_TICK) ? '0 : tick_q + 1'b1;
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    data_d   = data_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    valid_d  = 1'b0;

    case (state_q)
      IDLE: begin
        tick_d   = '0;
        bitCnt_d = '0;
        // Only a genuine high-to-low transition starts a frame, so a held-low break never retriggers.
        if (rxPrev_q && !rxS_q) begin
          state_d = START;
        end
      end
      START: begin
        if (tick_q == START_TICK) begin
          if (sampleBit) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            tick_d  = '0;
          end
        end
      end
      DATA: begin
        if (tick_q == LAST_TICK) begin
          shift_d = {sampleBit, shift_q[DATA_W-1:1]};
          if (bitCnt_q == LAST_BIT) begin
            bitCnt_d = '0;
            state_d  = PARITY;
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tick_q == LAST_TICK) begin
          par_d   = sampleBit;
          state_d = STOP;
        end
      end
      STOP: begin
        // Leaving at the stop-bit centre leaves half a bit to catch a back-to-back start edge.
        if (tick_q == LAST_TICK) begin
          data_d  = shift_q;
          perr_d  = ((^shift_q) ^ par_q) != PAR_ODD;
          ferr_d  = ~sampleBit;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rx.RX_data_out   = data_q;
  assign rx.RX_valid      = valid_q;
  assign rx.RX_busy       = (state_q != IDLE);
  assign rx.RX_parity_err = perr_q;
  assign rx.RX_frame_err  = ferr_q;

endmodule
